// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: data width, command encoding and the
// address-width helper used by every slave hanging off the crossbar.
package xbar_pkg;

  localparam int DW = 32;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  // Slave-side address width once the crossbar has consumed its select bits.
  function automatic int slave_aw(input int n_slaves);
    return 32 - $clog2(n_slaves);
  endfunction

endpackage

// File: rtl/mem_slave_chk.sv
// Protocol properties of the mem_slave response side.
module mem_slave_chk #(
  parameter int DW = 32
) (
  input logic          clk,
  input logic          rst,
  input logic          ack,
  input logic          resp,
  input logic          busy,
  input logic [DW-1:0] rdata
);

  ap_ack_resp_excl: assert property (@(posedge clk) disable iff (rst) !(ack && resp));
  ap_rdata_quiet:   assert property (@(posedge clk) disable iff (rst) (resp || (rdata == '0)));
  ap_ack_busy:      assert property (@(posedge clk) disable iff (rst) (!ack || busy));
  ap_resp_busy:     assert property (@(posedge clk) disable iff (rst) (!resp || busy));

endmodule

// File: rtl/sp_ram.sv
// Single-port word memory: synchronous write, registered read.
// The read register holds its value between reads; contents are never reset.
module sp_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem_r [DEPTH];
  logic [DW-1:0] q_r;

  // Storage array and read register; a write cycle leaves the read register untouched.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_r[idx] <= wdata;
      end else begin
        q_r <= mem_r[idx];
      end
    end
  end

  assign rdata = q_r;

endmodule

// File: rtl/mem_slave.sv
// Crossbar memory slave: one outstanding transaction, programmable ack and
// read-response latency, sticky overrun flag and completion counters.
module mem_slave
  import xbar_pkg::*;
#(
  parameter int AW       = 30,
  parameter int DW       = xbar_pkg::DW,
  parameter int DEPTH    = 1024,
  parameter int ACK_LAT  = 0,
  parameter int RESP_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          cmd,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic          resp,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          err_ovr,
  output logic [15:0]   wr_cnt,
  output logic [15:0]   rd_cnt
);

  localparam int         IW        = $clog2(DEPTH);
  localparam logic [3:0] ACK_LAT4  = 4'(ACK_LAT);
  localparam logic [3:0] RESP_LAT4 = 4'(RESP_LAT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACK_WAIT  = 2'd1,
    RESP_WAIT = 2'd2
  } state_e;

  state_e        state_r;
  logic [3:0]    cnt_r;
  logic          cmd_r;
  logic [IW-1:0] idx_r;
  logic [DW-1:0] wdata_r;
  logic          ack_r;
  logic          resp_r;
  logic          busy_r;
  logic          err_ovr_r;
  logic [15:0]   wr_cnt_r;
  logic [15:0]   rd_cnt_r;

  logic          ram_en_s;
  logic          ram_we_s;
  logic [DW-1:0] ram_q_s;

  // Upper address bits alias onto the same words by design.
  if (AW > IW) begin : g_alias
    logic unused_addr_s;
    assign unused_addr_s = ^addr[AW-1:IW];
  end

  // Memory access happens on the ack cycle; reset blocks a pending write.
  always_comb begin
    ram_en_s = 1'b0;
    ram_we_s = 1'b0;
    if (!rst && (state_r == ACK_WAIT) && (cnt_r == 4'd0)) begin
      ram_en_s = 1'b1;
      ram_we_s = (cmd_r == CMD_WR);
    end else begin
      ram_en_s = 1'b0;
      ram_we_s = 1'b0;
    end
  end

  sp_ram #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en_s),
    .we   (ram_we_s),
    .idx  (idx_r),
    .wdata(wdata_r),
    .rdata(ram_q_s)
  );

  // Transaction FSM with registered strobes, busy, overrun flag and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      cmd_r     <= CMD_RD;
      idx_r     <= '0;
      wdata_r   <= '0;
      ack_r     <= 1'b0;
      resp_r    <= 1'b0;
      busy_r    <= 1'b0;
      err_ovr_r <= 1'b0;
      wr_cnt_r  <= 16'd0;
      rd_cnt_r  <= 16'd0;
    end else begin
      if (req && (state_r != IDLE)) begin
        err_ovr_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          ack_r  <= 1'b0;
          resp_r <= 1'b0;
          if (req) begin
            cmd_r   <= cmd;
            idx_r   <= addr[IW-1:0];
            wdata_r <= wdata;
            cnt_r   <= ACK_LAT4;
            busy_r  <= 1'b1;
            ack_r   <= (ACK_LAT4 == 4'd0);
            state_r <= ACK_WAIT;
          end
        end
        ACK_WAIT: begin
          if (cnt_r == 4'd0) begin
            ack_r <= 1'b0;
            if (cmd_r == CMD_WR) begin
              wr_cnt_r <= wr_cnt_r + 16'd1;
              busy_r   <= 1'b0;
              state_r  <= IDLE;
            end else begin
              cnt_r   <= RESP_LAT4 - 4'd1;
              resp_r  <= (RESP_LAT4 == 4'd1);
              state_r <= RESP_WAIT;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
            ack_r <= (cnt_r == 4'd1);
          end
        end
        RESP_WAIT: begin
          if (cnt_r == 4'd0) begin
            resp_r   <= 1'b0;
            rd_cnt_r <= rd_cnt_r + 16'd1;
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end else begin
            cnt_r  <= cnt_r - 4'd1;
            resp_r <= (cnt_r == 4'd1);
          end
        end
        default: begin
          ack_r   <= 1'b0;
          resp_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // The read register is stable from the ack edge until the next request.
  assign rdata   = resp_r ? ram_q_s : '0;
  assign ack     = ack_r;
  assign resp    = resp_r;
  assign busy    = busy_r;
  assign err_ovr = err_ovr_r;
  assign wr_cnt  = wr_cnt_r;
  assign rd_cnt  = rd_cnt_r;

  mem_slave_chk #(
    .DW(DW)
  ) u_chk (
    .clk  (clk),
    .rst  (rst),
    .ack  (ack_r),
    .resp (resp_r),
    .busy (busy_r),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_mem_slave.sv
// Scoreboard bench for mem_slave: two instances with different latencies,
// directed stimulus pushes expected ack/resp events, a monitor pops and compares.
module tb_mem_slave;
  import xbar_pkg::*;

  localparam int AW  = 30;
  localparam int AL0 = 0;
  localparam int RL0 = 1;
  localparam int AL1 = 3;
  localparam int RL1 = 2;

  logic        clk = 1'b0;
  logic        rst     [2];
  logic        req     [2];
  logic        cmd     [2];
  logic [AW-1:0] addr  [2];
  logic [31:0] wdata   [2];
  logic        ack     [2];
  logic        resp    [2];
  logic [31:0] rdata   [2];
  logic        busy    [2];
  logic        err_ovr [2];
  logic [15:0] wr_cnt  [2];
  logic [15:0] rd_cnt  [2];

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int          dut;
    bit          is_resp;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_slave #(.AW(AW), .DW(32), .DEPTH(1024), .ACK_LAT(AL0), .RESP_LAT(RL0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .cmd(cmd[0]), .addr(addr[0]), .wdata(wdata[0]),
    .ack(ack[0]), .resp(resp[0]), .rdata(rdata[0]), .busy(busy[0]), .err_ovr(err_ovr[0]),
    .wr_cnt(wr_cnt[0]), .rd_cnt(rd_cnt[0])
  );

  mem_slave #(.AW(AW), .DW(32), .DEPTH(1024), .ACK_LAT(AL1), .RESP_LAT(RL1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .cmd(cmd[1]), .addr(addr[1]), .wdata(wdata[1]),
    .ack(ack[1]), .resp(resp[1]), .rdata(rdata[1]), .busy(busy[1]), .err_ovr(err_ovr[1]),
    .wr_cnt(wr_cnt[1]), .rd_cnt(rd_cnt[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int find_first(input int d);
    for (int k = 0; k < sbq.size(); k++) begin
      if (sbq[k].dut == d) return k;
    end
    return -1;
  endfunction

  task automatic take(input int d, input bit is_resp, input logic [31:0] dat);
    int k;
    k = find_first(d);
    if (k < 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s dut%0d: got pulse at cycle %0d required none",
               is_resp ? "resp" : "ack", d, cyc);
    end else begin
      check($sformatf("kind_is_resp dut%0d", d), 32'(is_resp), 32'(sbq[k].is_resp));
      check($sformatf("%s_cycle dut%0d", is_resp ? "resp" : "ack", d), cyc, sbq[k].cyc);
      if (is_resp) check($sformatf("rdata dut%0d", d), dat, sbq[k].data);
      sbq.delete(k);
    end
  endtask

  // Monitor: match every ack/resp pulse against the scoreboard, then flag overdue entries.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if ((ack[i] === 1'b1) && (resp[i] === 1'b1))
        check($sformatf("ack_resp_same_cycle dut%0d", i), 32'd1, 32'd0);
      if (ack[i] === 1'b1) take(i, 1'b0, 32'h0);
      if (resp[i] === 1'b1) take(i, 1'b1, rdata[i]);
    end
    for (int k = sbq.size() - 1; k >= 0; k--) begin
      if (sbq[k].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_%s dut%0d: got nothing by cycle %0d required pulse at %0d",
                 sbq[k].is_resp ? "resp" : "ack", sbq[k].dut, cyc, sbq[k].cyc);
        sbq.delete(k);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flush(input int d);
    for (int k = sbq.size() - 1; k >= 0; k--) begin
      if (sbq[k].dut == d) sbq.delete(k);
    end
  endtask

  // Drive a one-cycle request and schedule its expected ack (and resp for reads).
  task automatic issue(input int d, input logic c, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd);
    int al;
    int rl;
    al = (d == 0) ? AL0 : AL1;
    rl = (d == 0) ? RL0 : RL1;
    req[d] = 1'b1; cmd[d] = c; addr[d] = a; wdata[d] = wd;
    sbq.push_back('{dut: d, is_resp: 1'b0, cyc: cyc + 1 + al, data: 32'h0});
    if (c == CMD_RD)
      sbq.push_back('{dut: d, is_resp: 1'b1, cyc: cyc + 1 + al + rl, data: exp_rd});
    tick(1);
    req[d] = 1'b0;
  endtask

  // Full transaction; returns on the first cycle a new request is legal.
  task automatic txn(input int d, input logic c, input logic [AW-1:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd);
    int al;
    int rl;
    al = (d == 0) ? AL0 : AL1;
    rl = (d == 0) ? RL0 : RL1;
    issue(d, c, a, wd, exp_rd);
    tick((c == CMD_RD) ? (1 + al + rl) : (1 + al));
  endtask

  task automatic check_idle(input int d, input string tag, input logic [15:0] wc, input logic [15:0] rc);
    check($sformatf("%s ack dut%0d", tag, d), 32'(ack[d]), 32'd0);
    check($sformatf("%s resp dut%0d", tag, d), 32'(resp[d]), 32'd0);
    check($sformatf("%s busy dut%0d", tag, d), 32'(busy[d]), 32'd0);
    check($sformatf("%s err_ovr dut%0d", tag, d), 32'(err_ovr[d]), 32'd0);
    check($sformatf("%s rdata dut%0d", tag, d), rdata[d], 32'd0);
    check($sformatf("%s wr_cnt dut%0d", tag, d), 32'(wr_cnt[d]), 32'(wc));
    check($sformatf("%s rd_cnt dut%0d", tag, d), 32'(rd_cnt[d]), 32'(rc));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req[i] = 1'b1; cmd[i] = CMD_WR;
      addr[i] = 30'd5; wdata[i] = 32'hBAD0_BAD0;
    end
    tick(3);
    for (int i = 0; i < 2; i++) check_idle(i, "reset", 16'd0, 16'd0);
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; rst[i] = 1'b0;
    end
    tick(2);
    for (int i = 0; i < 2; i++) check_idle(i, "post_reset", 16'd0, 16'd0);

    // ACK_LAT=0 write: busy only in the ack cycle
    issue(0, CMD_WR, 30'd5, 32'hDEAD_BEEF, 32'h0);
    check("busy_ack_cycle dut0", 32'(busy[0]), 32'd1);
    tick(1);
    check("busy_after_write dut0", 32'(busy[0]), 32'd0);
    check("wr_cnt_first dut0", 32'(wr_cnt[0]), 32'd1);

    // ACK_LAT=3 / RESP_LAT=2 read-back
    txn(1, CMD_WR, 30'd5, 32'hDEAD_BEEF, 32'h0);
    txn(1, CMD_RD, 30'd5, 32'h0, 32'hDEAD_BEEF);
    check("wr_cnt dut1", 32'(wr_cnt[1]), 32'd1);
    check("rd_cnt dut1", 32'(rd_cnt[1]), 32'd1);

    // Aliasing: upper address bits ignored
    txn(0, CMD_WR, 30'h403, 32'h0000_0011, 32'h0);
    txn(0, CMD_RD, 30'h003, 32'h0, 32'h0000_0011);

    // Back-to-back, each request in the cycle after the previous completion
    txn(0, CMD_WR, 30'h010, 32'hA5A5_0001, 32'h0);
    txn(0, CMD_WR, 30'h7FF, 32'h5A5A_F00D, 32'h0);
    txn(0, CMD_RD, 30'h010, 32'h0, 32'hA5A5_0001);
    txn(0, CMD_RD, 30'h3FF, 32'h0, 32'h5A5A_F00D);
    check("b2b wr_cnt dut0", 32'(wr_cnt[0]), 32'd4);
    check("b2b rd_cnt dut0", 32'(rd_cnt[0]), 32'd3);
    check("b2b err_ovr dut0", 32'(err_ovr[0]), 32'd0);

    // Overrun: second request lands in the ack cycle and must be dropped
    issue(0, CMD_WR, 30'd7, 32'h0000_0077, 32'h0);
    req[0] = 1'b1; cmd[0] = CMD_RD; addr[0] = 30'd7;
    tick(1);
    req[0] = 1'b0;
    check("ovr err_ovr dut0", 32'(err_ovr[0]), 32'd1);
    check("ovr busy dut0", 32'(busy[0]), 32'd0);
    check("ovr wr_cnt dut0", 32'(wr_cnt[0]), 32'd5);
    check("ovr rd_cnt dut0", 32'(rd_cnt[0]), 32'd3);
    tick(5);
    check("ovr sticky dut0", 32'(err_ovr[0]), 32'd1);
    txn(0, CMD_RD, 30'd7, 32'h0, 32'h0000_0077);
    check("ovr sticky after txn dut0", 32'(err_ovr[0]), 32'd1);
    check("rd_cnt after ovr dut0", 32'(rd_cnt[0]), 32'd4);

    // Reset during RESP_WAIT: response dropped, next request served
    issue(1, CMD_RD, 30'd5, 32'h0, 32'hDEAD_BEEF);
    tick(4);
    check("busy resp_wait dut1", 32'(busy[1]), 32'd1);
    rst[1] = 1'b1;
    flush(1);
    tick(1);
    check_idle(1, "rst_resp_wait", 16'd0, 16'd0);
    rst[1] = 1'b0;
    tick(1);
    txn(1, CMD_RD, 30'd5, 32'h0, 32'hDEAD_BEEF);
    check("rd_cnt after rst dut1", 32'(rd_cnt[1]), 32'd1);

    // Reset during ACK_WAIT of a write: the write must not land
    issue(1, CMD_WR, 30'd5, 32'h0BAD_0BAD, 32'h0);
    tick(1);
    rst[1] = 1'b1;
    flush(1);
    tick(1);
    rst[1] = 1'b0;
    tick(4);
    check("aborted wr_cnt dut1", 32'(wr_cnt[1]), 32'd0);
    txn(1, CMD_RD, 30'd5, 32'h0, 32'hDEAD_BEEF);

    // Reset clears the sticky overrun flag and counters
    rst[0] = 1'b1;
    tick(1);
    rst[0] = 1'b0;
    check_idle(0, "rst_clear", 16'd0, 16'd0);
    tick(1);

    tick(10);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
